// File: rtl/cpu_multicycle.sv
// -----------------------------------------------------------------------------
// cpu_multicycle
//   Multi-cycle RV32I subset core (R/I ALU ops, LW, SW, branches, JAL, JALR,
//   LUI, AUIPC) sharing one word-wide memory port for fetch and data.
//   Each instruction walks FETCH -> DECODE -> EXEC [-> MEM] [-> WB].
//   Illegal encodings and misaligned LW/SW either park the core in HALT
//   (HALT_ON_ILLEGAL=1) or retire as a NOP (HALT_ON_ILLEGAL=0).
//   Instruction fetch presents pc as-is; jump targets are not alignment
//   checked (JALR only clears bit 0).
//
// Parameters
//   RESET_PC        PC loaded on reset
//   CNT_W           width of the retired-instruction counter (8..64)
//   HALT_ON_ILLEGAL 1 = halt on illegal/misaligned, 0 = retire as NOP
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   mem_req    request valid, held until mem_ready completes it
//   mem_we     1 = word write, 0 = word read
//   mem_addr   byte address
//   mem_wdata  store data
//   mem_rdata  read data, sampled when mem_req && mem_ready
//   mem_ready  transfer-complete strobe
//   pc         architectural PC
//   halted     high while in HALT
//   instret    retired-instruction count (wraps)
// -----------------------------------------------------------------------------
module cpu_multicycle #(
   parameter logic [31:0] RESET_PC        = 32'h0000_0000,
   parameter int          CNT_W           = 32,
   parameter int          HALT_ON_ILLEGAL = 1
) (
   input  logic             clk,
   input  logic             reset,
   output logic             mem_req,
   output logic             mem_we,
   output logic [31:0]      mem_addr,
   output logic [31:0]      mem_wdata,
   input  logic [31:0]      mem_rdata,
   input  logic             mem_ready,
   output logic [31:0]      pc,
   output logic             halted,
   output logic [CNT_W-1:0] instret
);

   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

   state_t      state;
   logic [31:0] ir;          // instruction register
   logic [31:0] rs1_q;       // operands latched in DECODE
   logic [31:0] rs2_q;
   logic [31:0] imm_q;
   logic [31:0] addr_q;      // data address for MEM
   logic [31:0] result_q;    // value written to rd in WB
   logic [31:0] next_pc_q;   // pc applied in WB
   logic        illegal_q;   // only reaches EXEC when HALT_ON_ILLEGAL=0
   logic [31:0] regs [0:31];

   // Instruction fields
   logic [6:0] opcode;
   logic [4:0] rd, rs1, rs2;
   logic [2:0] funct3;
   logic [6:0] funct7;

   assign opcode = ir[6:0];
   assign rd     = ir[11:7];
   assign funct3 = ir[14:12];
   assign rs1    = ir[19:15];
   assign rs2    = ir[24:20];
   assign funct7 = ir[31:25];

   // ---------------------------------------------------------------------------
   // Decode: immediate selection and legality
   // ---------------------------------------------------------------------------
   logic [31:0] imm_dec;
   logic        illegal;

   // NOTE: every variable assigned in an always_comb gets a default first so
   // no path leaves it holding its old value, which would infer a latch.
   always_comb begin
      imm_dec = {{20{ir[31]}}, ir[31:20]};
      illegal = 1'b0;
      case (opcode)
         OP_STORE:  imm_dec = {{20{ir[31]}}, ir[31:25], ir[11:7]};
         OP_BRANCH: imm_dec = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
         OP_JAL:    imm_dec = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
         OP_LUI,
         OP_AUIPC:  imm_dec = {ir[31:12], 12'd0};
         default:   ;
      endcase
      case (opcode)
         // Only SUB and SRA use the alternate funct7
         OP_REG:    illegal = !(funct7 == 7'b0000000 ||
                                (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)));
         OP_IMM: begin
            if (funct3 == 3'b001)
               illegal = (funct7 != 7'b0000000);
            else if (funct3 == 3'b101)
               illegal = !(funct7 == 7'b0000000 || funct7 == 7'b0100000);
         end
         OP_LOAD,
         OP_STORE:  illegal = (funct3 != 3'b010);
         OP_BRANCH: illegal = (funct3 == 3'b010 || funct3 == 3'b011);
         OP_JALR:   illegal = (funct3 != 3'b000);
         OP_JAL,
         OP_LUI,
         OP_AUIPC:  illegal = 1'b0;
         default:   illegal = 1'b1;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Execute: ALU, branch compare, data address
   // ---------------------------------------------------------------------------
   logic [31:0] alu_b, alu_y, eff_addr;
   logic        alt, taken;

   assign eff_addr = rs1_q + imm_q;

   always_comb begin
      alu_b = (opcode == OP_REG) ? rs2_q : imm_q;
      // ir[30] selects SUB/SRA; for immediates it is an immediate bit except on shifts
      alt   = ir[30] && (opcode == OP_REG || funct3 == 3'b101);
      case (funct3)
         3'b000:  alu_y = alt ? rs1_q - alu_b : rs1_q + alu_b;
         3'b001:  alu_y = rs1_q << alu_b[4:0];
         3'b010:  alu_y = {31'd0, $signed(rs1_q) < $signed(alu_b)};
         3'b011:  alu_y = {31'd0, rs1_q < alu_b};
         3'b100:  alu_y = rs1_q ^ alu_b;
         3'b101:  alu_y = alt ? 32'($signed(rs1_q) >>> alu_b[4:0]) : rs1_q >> alu_b[4:0];
         3'b110:  alu_y = rs1_q | alu_b;
         default: alu_y = rs1_q & alu_b;
      endcase
   end

   always_comb begin
      taken = 1'b0;
      case (funct3)
         3'b000:  taken = (rs1_q == rs2_q);
         3'b001:  taken = (rs1_q != rs2_q);
         3'b100:  taken = ($signed(rs1_q) <  $signed(rs2_q));
         3'b101:  taken = ($signed(rs1_q) >= $signed(rs2_q));
         3'b110:  taken = (rs1_q <  rs2_q);
         3'b111:  taken = (rs1_q >= rs2_q);
         default: taken = 1'b0;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Memory port: decoded from registered state so address/data/we cannot move
   // while a request waits. Gating with reset drops the request immediately.
   // ---------------------------------------------------------------------------
   assign mem_req   = !reset && (state == FETCH || state == MEM);
   assign mem_we    = (state == MEM) && (opcode == OP_STORE);
   assign mem_addr  = (state == FETCH) ? pc : addr_q;
   assign mem_wdata = rs2_q;
   assign halted    = (state == HALT);

   // ---------------------------------------------------------------------------
   // Control FSM and datapath registers
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= FETCH;
         pc        <= RESET_PC;
         instret   <= '0;
         ir        <= '0;
         rs1_q     <= '0;
         rs2_q     <= '0;
         imm_q     <= '0;
         addr_q    <= '0;
         result_q  <= '0;
         next_pc_q <= '0;
         illegal_q <= 1'b0;
      end else begin
         case (state)
            FETCH: begin
               if (mem_ready) begin
                  ir    <= mem_rdata;
                  state <= DECODE;
               end
            end

            DECODE: begin
               rs1_q     <= (rs1 == 5'd0) ? 32'd0 : regs[rs1];
               rs2_q     <= (rs2 == 5'd0) ? 32'd0 : regs[rs2];
               imm_q     <= imm_dec;
               illegal_q <= illegal;
               if (illegal && HALT_ON_ILLEGAL != 0)
                  state <= HALT;
               else
                  state <= EXEC;
            end

            EXEC: begin
               next_pc_q <= pc + 32'd4;
               if (illegal_q) begin
                  pc      <= pc + 32'd4;
                  instret <= instret + CNT_W'(1);
                  state   <= FETCH;
               end else begin
                  case (opcode)
                     OP_BRANCH: begin
                        pc      <= taken ? pc + imm_q : pc + 32'd4;
                        instret <= instret + CNT_W'(1);
                        state   <= FETCH;
                     end
                     OP_LOAD,
                     OP_STORE: begin
                        if (eff_addr[1:0] != 2'b00) begin
                           if (HALT_ON_ILLEGAL != 0) begin
                              state <= HALT;
                           end else begin
                              pc      <= pc + 32'd4;
                              instret <= instret + CNT_W'(1);
                              state   <= FETCH;
                           end
                        end else begin
                           addr_q <= eff_addr;
                           state  <= MEM;
                        end
                     end
                     OP_JAL: begin
                        result_q  <= pc + 32'd4;
                        next_pc_q <= pc + imm_q;
                        state     <= WB;
                     end
                     OP_JALR: begin
                        result_q  <= pc + 32'd4;
                        next_pc_q <= eff_addr & ~32'd1;
                        state     <= WB;
                     end
                     OP_LUI: begin
                        result_q <= imm_q;
                        state    <= WB;
                     end
                     OP_AUIPC: begin
                        result_q <= pc + imm_q;
                        state    <= WB;
                     end
                     default: begin
                        result_q <= alu_y;
                        state    <= WB;
                     end
                  endcase
               end
            end

            MEM: begin
               if (mem_ready) begin
                  if (opcode == OP_STORE) begin
                     pc      <= pc + 32'd4;
                     instret <= instret + CNT_W'(1);
                     state   <= FETCH;
                  end else begin
                     result_q <= mem_rdata;
                     state    <= WB;
                  end
               end
            end

            WB: begin
               pc      <= next_pc_q;
               instret <= instret + CNT_W'(1);
               state   <= FETCH;
            end

            default: state <= HALT;   // HALT: frozen until reset
         endcase
      end
   end

   // NOTE: the register file has no reset; x0 is never written and reads of
   // index 0 are forced to zero at the read mux instead.
   always_ff @(posedge clk) begin
      if (state == WB && rd != 5'd0)
         regs[rd] <= result_q;
   end

endmodule

// File: tb/tb_cpu_multicycle.sv
// -----------------------------------------------------------------------------
// tb_cpu_multicycle
//   Directed bench for cpu_multicycle: small hand-assembled programs run from
//   a word memory model with controllable mem_ready; results are observed on
//   pc/instret/halted, on the memory port, and in memory after stores.
// -----------------------------------------------------------------------------
module tb_cpu_multicycle;

   localparam logic [6:0] OP_REG  = 7'b0110011;
   localparam logic [6:0] OP_IMM  = 7'b0010011;
   localparam logic [6:0] OP_LUI  = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        mem_req, mem_we, halted;
   logic [31:0] mem_addr, mem_wdata, mem_rdata, pc, instret;
   logic        mem_ready = 1'b1;

   int total = 0;
   int bad   = 0;

   // Memory model (1 KiB, word indexed by addr[9:2])
   logic [31:0] mem [0:255];
   logic        clr = 1'b0;
   logic        load_we = 1'b0;
   logic [7:0]  load_idx = '0;
   logic [31:0] load_data = '0;
   int          wr_count = 0;
   logic [31:0] last_waddr = '0;
   logic [31:0] last_wdata = '0;

   always #5 clk = ~clk;

   cpu_multicycle #(
      .RESET_PC        (32'h0000_0000),
      .CNT_W           (32),
      .HALT_ON_ILLEGAL (1)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready),
      .pc        (pc),
      .halted    (halted),
      .instret   (instret)
   );

   assign mem_rdata = mem[mem_addr[9:2]];

   always @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < 256; i++) mem[i] <= '0;
         wr_count   <= 0;
         last_waddr <= '0;
         last_wdata <= '0;
      end else if (load_we) begin
         mem[load_idx] <= load_data;
      end else if (mem_req && mem_ready && mem_we) begin
         mem[mem_addr[9:2]] <= mem_wdata;
         wr_count   <= wr_count + 1;
         last_waddr <= mem_addr;
         last_wdata <= mem_wdata;
      end
   end

   // ---------------- encoders ----------------
   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] op);
      return {imm, rs1, f3, rd, op};
   endfunction

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, OP_REG};
   endfunction

   function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1);
      return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
   endfunction

   function automatic logic [31:0] enc_lw(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [4:0] rd);
      return {imm, rs1, 3'b010, rd, 7'b0000011};
   endfunction

   function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
   endfunction

   function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
   endfunction

   function automatic logic [31:0] enc_jalr(input logic [11:0] imm, input logic [4:0] rs1,
                                            input logic [4:0] rd);
      return {imm, rs1, 3'b000, rd, 7'b1100111};
   endfunction

   // ---------------- helpers ----------------
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic begin_test();
      reset     = 1'b1;
      mem_ready = 1'b1;
      clr       = 1'b1;
      @(posedge clk); #1;
      clr       = 1'b0;
   endtask

   task automatic put(input logic [31:0] addr, input logic [31:0] word);
      load_idx  = addr[9:2];
      load_data = word;
      load_we   = 1'b1;
      @(posedge clk); #1;
      load_we   = 1'b0;
   endtask

   task automatic go();
      @(negedge clk);
      reset = 1'b0;
      #1;
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_halt(input int max_cycles);
      for (int i = 0; i < max_cycles && !halted; i++) step(1);
   endtask

   task automatic load_branch_prog(input logic [2:0] f3_at_10);
      begin_test();
      put(32'h00, {20'h80000, 5'd1, OP_LUI});             // LUI  x1,0x80000
      put(32'h04, enc_i(12'd1, 5'd0, 3'b000, 5'd2, OP_IMM)); // ADDI x2,x0,1
      put(32'h08, enc_i(12'd0, 5'd0, 3'b000, 5'd0, OP_IMM)); // NOP
      put(32'h0C, enc_i(12'd0, 5'd0, 3'b000, 5'd0, OP_IMM)); // NOP
      put(32'h10, enc_b(13'd16, 5'd2, 5'd1, f3_at_10));     // Bxx x1,x2,+16
      put(32'h20, enc_b(13'd8, 5'd2, 5'd1, 3'b111));        // BGEU x1,x2,+8
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // ---- Reset values and two dependent ADDIs on zero-wait memory ----
      begin_test();
      check("rst_mem_req", mem_req, 0);
      check("rst_halted", halted, 0);
      check("rst_pc", pc, 32'h0);
      check("rst_instret", instret, 0);
      put(32'h00, enc_i(12'd5, 5'd0, 3'b000, 5'd1, OP_IMM));     // ADDI x1,x0,5
      put(32'h04, enc_i(12'hFF9, 5'd1, 3'b000, 5'd2, OP_IMM));   // ADDI x2,x1,-7
      put(32'h08, enc_s(12'h200, 5'd2, 5'd0));                   // SW   x2,0x200(x0)
      go();
      check("first_req", mem_req, 1);
      check("first_addr", mem_addr, 32'h0);
      check("first_we", mem_we, 0);
      step(8);
      check("addi_pc", pc, 32'h8);
      check("addi_instret", instret, 2);
      step(4);
      check("addi_wcount", wr_count, 1);
      check("addi_waddr", last_waddr, 32'h200);
      check("addi_x2", last_wdata, 32'hFFFF_FFFE);
      step(2);                                                   // word 0 at 0xC is illegal
      check("illegal_halt", halted, 1);
      check("illegal_pc", pc, 32'hC);
      check("illegal_req", mem_req, 0);

      // ---- Fetch stalled 3 cycles ----
      begin_test();
      put(32'h00, enc_i(12'd5, 5'd0, 3'b000, 5'd1, OP_IMM));
      mem_ready = 1'b0;
      go();
      check("stall_req0", mem_req, 1);
      for (int i = 0; i < 3; i++) begin
         step(1);
         check("stall_req", mem_req, 1);
         check("stall_addr", mem_addr, 32'h0);
      end
      mem_ready = 1'b1;
      step(1);
      check("stall_decode_req", mem_req, 0);
      step(3);
      check("stall_instret", instret, 1);
      check("stall_pc", pc, 32'h4);

      // ---- Signed vs unsigned branches ----
      load_branch_prog(3'b100);                                  // BLT at 0x10
      go();
      step(16);
      check("blt_pc_before", pc, 32'h10);
      step(2);
      check("blt_pc_mid", pc, 32'h10);
      step(1);
      check("blt_taken_pc", pc, 32'h20);
      check("blt_instret", instret, 5);
      step(3);
      check("bgeu_taken_pc", pc, 32'h28);
      load_branch_prog(3'b110);                                  // BLTU at 0x10
      go();
      step(19);
      check("bltu_not_taken_pc", pc, 32'h14);

      // ---- SW then LW round trip ----
      begin_test();
      put(32'h00, enc_i(12'h100, 5'd0, 3'b000, 5'd1, OP_IMM));   // ADDI x1,x0,0x100
      put(32'h04, {20'h12345, 5'd2, OP_LUI});                    // LUI  x2,0x12345
      put(32'h08, enc_i(12'h678, 5'd2, 3'b000, 5'd2, OP_IMM));   // ADDI x2,x2,0x678
      put(32'h0C, enc_s(12'd4, 5'd2, 5'd1));                     // SW   x2,4(x1)
      put(32'h10, enc_lw(12'd4, 5'd1, 5'd3));                    // LW   x3,4(x1)
      put(32'h14, enc_s(12'd8, 5'd3, 5'd1));                     // SW   x3,8(x1)
      go();
      step(15);
      check("sw_req", mem_req, 1);
      check("sw_we", mem_we, 1);
      check("sw_addr", mem_addr, 32'h104);
      check("sw_wdata", mem_wdata, 32'h1234_5678);
      step(1);
      check("sw_waddr", last_waddr, 32'h104);
      check("sw_pc", pc, 32'h10);
      step(4);
      check("lw_pc_4cyc", pc, 32'h10);
      step(1);
      check("lw_pc_5cyc", pc, 32'h14);
      check("lw_instret", instret, 5);
      step(4);
      check("lw_x3_waddr", last_waddr, 32'h108);
      check("lw_x3_wdata", last_wdata, 32'h1234_5678);
      check("lw_wcount", wr_count, 2);

      // ---- JALR to odd target ----
      begin_test();
      put(32'h00, enc_i(12'h040, 5'd0, 3'b000, 5'd6, OP_IMM));   // ADDI x6,x0,0x40
      put(32'h04, enc_i(12'd0, 5'd0, 3'b000, 5'd0, OP_IMM));     // NOP
      put(32'h08, enc_jalr(12'd3, 5'd6, 5'd5));                  // JALR x5,x6,3
      go();
      step(12);
      check("jalr_pc", pc, 32'h42);
      check("jalr_instret", instret, 3);
      check("jalr_fetch_addr", mem_addr, 32'h42);

      // ---- JALR clears bit 0 and links pc+4 ----
      begin_test();
      put(32'h00, enc_i(12'h03E, 5'd0, 3'b000, 5'd6, OP_IMM));   // ADDI x6,x0,0x3E
      put(32'h04, enc_i(12'd0, 5'd0, 3'b000, 5'd0, OP_IMM));     // NOP
      put(32'h08, enc_jalr(12'd3, 5'd6, 5'd5));                  // JALR x5,x6,3 -> 0x40
      put(32'h40, enc_s(12'h200, 5'd5, 5'd0));                   // SW   x5,0x200(x0)
      go();
      step(12);
      check("jalr_bit0_pc", pc, 32'h40);
      step(4);
      check("jalr_link", last_wdata, 32'hC);

      // ---- Misaligned LW halts and freezes ----
      begin_test();
      put(32'h00, enc_i(12'h100, 5'd0, 3'b000, 5'd1, OP_IMM));   // ADDI x1,x0,0x100
      put(32'h04, enc_lw(12'd2, 5'd1, 5'd3));                    // LW   x3,2(x1)
      go();
      step(7);
      check("mis_halted", halted, 1);
      check("mis_req", mem_req, 0);
      step(5);
      check("mis_halted_hold", halted, 1);
      check("mis_pc_frozen", pc, 32'h4);
      check("mis_instret_frozen", instret, 1);
      check("mis_req_hold", mem_req, 0);

      // ---- Reset in the middle of a stalled store ----
      begin_test();
      put(32'h00, enc_i(12'd1, 5'd0, 3'b000, 5'd1, OP_IMM));     // ADDI x1,x0,1
      put(32'h04, enc_s(12'h200, 5'd1, 5'd0));                   // SW   x1,0x200(x0)
      go();
      step(7);
      mem_ready = 1'b0;
      check("mid_req", mem_req, 1);
      check("mid_we", mem_we, 1);
      check("mid_instret", instret, 1);
      step(2);
      #2;
      reset = 1'b1;
      #1;
      check("async_req_drop", mem_req, 0);
      check("async_pc", pc, 32'h0);
      check("async_instret", instret, 0);
      check("async_no_write", wr_count, 0);
      mem_ready = 1'b1;
      step(2);
      check("rst_hold_req", mem_req, 0);
      go();
      check("rel_req", mem_req, 1);
      check("rel_addr", mem_addr, 32'h0);
      check("rel_we", mem_we, 0);
      check("rel_instret", instret, 0);

      // ---- ALU mix, x0 discard, AUIPC, JAL ----
      begin_test();
      put(32'h00, enc_i(12'hFF0, 5'd0, 3'b000, 5'd1, OP_IMM));   // ADDI x1,x0,-16
      put(32'h04, enc_i(12'd4, 5'd0, 3'b000, 5'd2, OP_IMM));     // ADDI x2,x0,4
      put(32'h08, enc_r(7'h20, 5'd2, 5'd1, 3'b101, 5'd3));       // SRA  x3,x1,x2
      put(32'h0C, enc_r(7'h00, 5'd2, 5'd1, 3'b101, 5'd4));       // SRL  x4,x1,x2
      put(32'h10, enc_r(7'h20, 5'd1, 5'd2, 3'b000, 5'd5));       // SUB  x5,x2,x1
      put(32'h14, enc_r(7'h00, 5'd2, 5'd1, 3'b010, 5'd6));       // SLT  x6,x1,x2
      put(32'h18, enc_r(7'h00, 5'd2, 5'd1, 3'b011, 5'd7));       // SLTU x7,x1,x2
      put(32'h1C, enc_i(12'd29, 5'd2, 3'b001, 5'd8, OP_IMM));    // SLLI x8,x2,29
      put(32'h20, enc_i(12'hFFF, 5'd1, 3'b100, 5'd9, OP_IMM));   // XORI x9,x1,-1
      put(32'h24, {20'h00001, 5'd10, OP_AUIPC});                 // AUIPC x10,1
      put(32'h28, enc_i(12'd5, 5'd0, 3'b000, 5'd0, OP_IMM));     // ADDI x0,x0,5
      put(32'h2C, enc_j(21'd8, 5'd11));                          // JAL  x11,+8
      for (int k = 0; k < 8; k++)
         put(32'h34 + 32'(k * 4), enc_s(12'h200 + 12'(k * 4), 5'(3 + k), 5'd0));
      put(32'h54, enc_s(12'h220, 5'd0, 5'd0));                   // SW x0,0x220
      put(32'h58, enc_s(12'h224, 5'd11, 5'd0));                  // SW x11,0x224
      put(32'h220, 32'hDEAD_BEEF);
      go();
      wait_halt(400);
      check("alu_halted", halted, 1);
      check("alu_pc", pc, 32'h5C);
      check("alu_instret", instret, 22);
      check("sra", mem[8'h80], 32'hFFFF_FFFF);
      check("srl", mem[8'h81], 32'h0FFF_FFFF);
      check("sub", mem[8'h82], 32'h0000_0014);
      check("slt", mem[8'h83], 32'h0000_0001);
      check("sltu", mem[8'h84], 32'h0000_0000);
      check("slli", mem[8'h85], 32'h8000_0000);
      check("xori", mem[8'h86], 32'h0000_000F);
      check("auipc", mem[8'h87], 32'h0000_1024);
      check("x0_zero", mem[8'h88], 32'h0000_0000);
      check("jal_link", mem[8'h89], 32'h0000_0030);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
